vault_alarm_ctrl: RTL
=====================

Name: vault_alarm_ctrl

Overview:
Parametrised, clocked successor to the combinational bank-vault alarm (alarm = door_open & (~business_hours | lockdown)).
- Monitors NDOORS vault doors and applies a programmable grace delay before alarming.
- Latches the alarm and records which doors caused it; the alarm clears only on operator ack.
- Drives the board LEDs/siren from clk_2 and exposes state, timer and event count for the LCD debug outputs.

Parameters:
NDOORS, 4, number of monitored doors (1..8)
DELAY_TICKS, 5, clk_2 cycles of grace in PRE_ALARM before ALARM (0 = no grace)
BLINK_TICKS, 2, clk_2 cycles per siren half-period (>=1)
EVW, 8, width of saturating alarm-event counter

Ports:
clk_2  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
door_open  input  NDOORS  1 = door i open
business_hours  input  1  1 = time lock released (doors may open legally)
lockdown  input  1  1 = emergency lockdown; any open door alarms immediately
ack  input  1  operator acknowledge/clear, level-sampled each cycle
alarm  output  1  registered; 1 in ALARM
pre_alarm  output  1  registered; 1 in PRE_ALARM
siren  output  1  registered; toggles every BLINK_TICKS cycles in ALARM, else 0
cause  output  NDOORS  sticky OR of violating doors since entering ALARM
timer  output  $clog2(DELAY_TICKS+1) (min 1)  remaining grace count
event_count  output  EVW  number of ALARM entries, saturating at all-ones
state  output  2  encoded FSM state, for the LCD

Behaviour:
- viol[i] = door_open[i] & (~business_hours | lockdown); any_viol = |viol. Combinational and sampled each edge.
- Reset (sync, priority over everything):
  - state=IDLE; alarm=0, pre_alarm=0, siren=0.
  - cause=0, timer=0, event_count=0, blink counter=0.
  - Reset mid-alarm aborts immediately; the siren drops on the same edge.
- FSM, encoding IDLE=0, PRE_ALARM=1, ALARM=2:
  - IDLE:
    - any_viol & (lockdown | DELAY_TICKS==0) -> ALARM.
    - any_viol otherwise -> PRE_ALARM, timer loaded with DELAY_TICKS-1.
  - PRE_ALARM:
    - !any_viol -> IDLE, timer=0 (door closed in time, no event).
    - lockdown -> ALARM.
    - timer==0 -> ALARM.
    - otherwise timer decrements by 1.
    - Total delay from first violating sample to alarm=1 is DELAY_TICKS+1 edges.
  - ALARM:
    - cause |= viol every cycle.
    - ack & !any_viol -> IDLE; cause, siren and blink counter cleared.
    - ack while any_viol -> ignored; stay in ALARM.
- Entry to ALARM:
  - On the transition edge: event_count += 1 unless already all-ones; cause = viol; siren=1; blink counter=0.
- Siren in ALARM:
  - Blink counter counts 0..BLINK_TICKS-1.
  - On the wrap, siren toggles.
  - Period = 2*BLINK_TICKS cycles.
- Outputs are registered: alarm/pre_alarm/state reflect the state after the edge (1-cycle latency from input sample).
- Simultaneous events:
  - In PRE_ALARM, lockdown and timer expiry together -> ALARM (single event count).
  - Door closes on the same cycle the timer hits 0 -> IDLE (close wins).
- Width rule: timer is never loaded above DELAY_TICKS-1; no underflow, since decrement happens only when timer>0.

Decomposition:
- Package vault_pkg holds:
  - typedef enum logic [1:0] vault_state_t {IDLE, PRE_ALARM, ALARM};
  - default parameter constants.
- One sub-module, vault_blinker (enable, counter, toggle output, parametrised by BLINK_TICKS), instantiated for the siren.
- FSM, timer, cause and event counter stay in vault_alarm_ctrl.

Test Plan (NDOORS=4, DELAY_TICKS=5, BLINK_TICKS=2):
1. Legal opening: business_hours=1, lockdown=0, door_open=4'b0011 for 20 cycles -> state stays IDLE, alarm=0, event_count=0.
2. Grace then alarm: business_hours=0, door_open=4'b0100 held.
   - pre_alarm=1 on the next edge; timer reads 4,3,2,1,0.
   - alarm=1 exactly 6 edges after the first sample; cause=4'b0100, event_count=1.
   - siren pattern 1,1,0,0,1,1...
3. Door closed in grace: as in 2, but door_open=0 after 3 cycles -> back to IDLE, alarm never 1, event_count unchanged.
4. Lockdown bypass: business_hours=1, lockdown=1, door_open=4'b1000 -> alarm=1 on the next edge, no PRE_ALARM cycle.
5. Ack rules:
   - In ALARM with door 0 still open, ack=1 -> remains ALARM.
   - Open door 2 too -> cause=4'b0101.
   - Close all doors, then ack=1 -> IDLE, cause=0, siren=0.
6. Reset and saturation:
   - Assert reset during ALARM -> all outputs 0 on the next edge.
   - With EVW=2, trigger 5 alarms -> event_count saturates at 3.

Source files
------------

// File: rtl/vault_pkg.sv
// ----------------------------------------------------------------------------
// vault_pkg
//   Shared types and defaults for the vault alarm controller.
//   - vault_state_t : encoded FSM state, also exported on the LCD debug port
//   - DEF_*         : default parameter values for the controller and blinker
//   - timer_width() : width of the grace timer for a given delay (min 1 bit)
// ----------------------------------------------------------------------------
package vault_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRE_ALARM = 2'd1,
        ALARM     = 2'd2
    } vault_state_t;

    localparam int unsigned DEF_NDOORS      = 4;
    localparam int unsigned DEF_DELAY_TICKS = 5;
    localparam int unsigned DEF_BLINK_TICKS = 2;
    localparam int unsigned DEF_EVW         = 8;

    // Enough bits to hold DELAY_TICKS; a zero delay still gets a 1-bit port.
    function automatic int unsigned timer_width(input int unsigned delay);
        int unsigned w;
        w = $clog2(delay + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/vault_blinker.sv
// ----------------------------------------------------------------------------
// vault_blinker
//   Siren square-wave generator. Starts high on 'start', then toggles every
//   BLINK_TICKS cycles while 'run' is held. With neither asserted the output
//   and counter are held at zero.
//
// Ports:
//   clk_2   in   system clock, rising edge
//   reset   in   synchronous, active-high reset
//   start   in   restart: output forced to 1, counter to 0
//   run     in   keep blinking (counter advances, toggles on wrap)
//   toggle  out  registered blink output
// ----------------------------------------------------------------------------
module vault_blinker
    import vault_pkg::*;
#(
    parameter int unsigned BLINK_TICKS = DEF_BLINK_TICKS
) (
    input  logic clk_2,
    input  logic reset,
    input  logic start,
    input  logic run,
    output logic toggle
);

    localparam int unsigned CW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_TICKS - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk_2) begin
        if (reset) begin
            count  <= '0;
            toggle <= 1'b0;
        end else if (start) begin
            count  <= '0;
            toggle <= 1'b1;
        end else if (run) begin
            if (count == LAST) begin
                count  <= '0;
                toggle <= ~toggle;
            end else begin
                count <= count + 1'b1;
            end
        end else begin
            count  <= '0;
            toggle <= 1'b0;
        end
    end

endmodule

// File: rtl/vault_alarm_ctrl.sv
// ----------------------------------------------------------------------------
// vault_alarm_ctrl
//   Clocked bank-vault alarm. A door that is open outside business hours (or
//   at any time during lockdown) is a violation. Violations start a grace
//   period (PRE_ALARM); if the door is still open when it runs out, or if
//   lockdown is active, the alarm latches (ALARM) until the operator acks
//   with all doors closed.
//
// Ports:
//   clk_2           in   system clock, rising edge
//   reset           in   synchronous, active-high reset (highest priority)
//   door_open       in   [NDOORS] 1 = door i open
//   business_hours  in   1 = time lock released
//   lockdown        in   1 = emergency lockdown, no grace period
//   ack             in   operator acknowledge, level-sampled
//   alarm           out  registered, 1 in ALARM
//   pre_alarm       out  registered, 1 in PRE_ALARM
//   siren           out  registered blink output while in ALARM
//   cause           out  [NDOORS] sticky OR of violating doors in ALARM
//   timer           out  [TW] remaining grace count
//   event_count     out  [EVW] saturating count of ALARM entries
//   state           out  [2] encoded FSM state
// ----------------------------------------------------------------------------
module vault_alarm_ctrl
    import vault_pkg::*;
#(
    parameter int unsigned NDOORS      = DEF_NDOORS,
    parameter int unsigned DELAY_TICKS = DEF_DELAY_TICKS,
    parameter int unsigned BLINK_TICKS = DEF_BLINK_TICKS,
    parameter int unsigned EVW         = DEF_EVW,
    localparam int unsigned TW         = timer_width(DELAY_TICKS)
) (
    input  logic              clk_2,
    input  logic              reset,
    input  logic [NDOORS-1:0] door_open,
    input  logic              business_hours,
    input  logic              lockdown,
    input  logic              ack,
    output logic              alarm,
    output logic              pre_alarm,
    output logic              siren,
    output logic [NDOORS-1:0] cause,
    output logic [TW-1:0]     timer,
    output logic [EVW-1:0]    event_count,
    output logic [1:0]        state
);

    // First PRE_ALARM value; together with the expiry edge this gives
    // DELAY_TICKS+1 edges from the first violating sample to alarm=1.
    localparam logic [TW-1:0] TIMER_LOAD = TW'((DELAY_TICKS > 0) ? DELAY_TICKS - 1 : 0);
    localparam bit NO_GRACE = (DELAY_TICKS == 0);

    vault_state_t      state_q;
    vault_state_t      state_d;
    logic [NDOORS-1:0] viol;
    logic              any_viol;
    logic              enter_alarm;
    logic              stay_alarm;

    assign viol     = door_open & {NDOORS{~business_hours | lockdown}};
    assign any_viol = |viol;

    // Next-state decode. In PRE_ALARM a closed door outranks everything,
    // so a close on the expiry cycle returns to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_viol) begin
                    state_d = (lockdown || NO_GRACE) ? ALARM : PRE_ALARM;
                end
            end
            PRE_ALARM: begin
                if (!any_viol) begin
                    state_d = IDLE;
                end else if (lockdown || (timer == '0)) begin
                    state_d = ALARM;
                end
            end
            ALARM: begin
                if (ack && !any_viol) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign enter_alarm = (state_d == ALARM) && (state_q != ALARM);
    assign stay_alarm  = (state_d == ALARM) && (state_q == ALARM);

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q     <= IDLE;
            alarm       <= 1'b0;
            pre_alarm   <= 1'b0;
            cause       <= '0;
            timer       <= '0;
            event_count <= '0;
        end else begin
            state_q   <= state_d;
            alarm     <= (state_d == ALARM);
            pre_alarm <= (state_d == PRE_ALARM);

            // Decrement only while staying in PRE_ALARM, which implies timer > 0.
            if ((state_q == IDLE) && (state_d == PRE_ALARM)) begin
                timer <= TIMER_LOAD;
            end else if ((state_q == PRE_ALARM) && (state_d == PRE_ALARM)) begin
                timer <= timer - 1'b1;
            end else begin
                timer <= '0;
            end

            if (enter_alarm) begin
                cause <= viol;
            end else if (stay_alarm) begin
                cause <= cause | viol;
            end else begin
                cause <= '0;
            end

            if (enter_alarm && (event_count != '1)) begin
                event_count <= event_count + 1'b1;
            end
        end
    end

    assign state = state_q;

    vault_blinker #(
        .BLINK_TICKS (BLINK_TICKS)
    ) u_blinker (
        .clk_2  (clk_2),
        .reset  (reset),
        .start  (enter_alarm),
        .run    (stay_alarm),
        .toggle (siren)
    );

endmodule
